// File: rtl/cc_outgoing_message_arbiter.sv
// rtl/cc_outgoing_message_arbiter.sv - per-class outgoing coherence FIFOs arbitrated onto one NI injection port
//
// Purpose:
//   Buffers request / response / forward messages from the cache controller's
//   last stage in three circular FIFOs and injects them one at a time into the
//   network interface. Responses win over forwards, forwards over requests;
//   a starvation counter force-grants requests after STARVE_LIMIT lost loads.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cc_{req,rsp,fwd}_valid/msg enqueue strobes and payloads (no ready)
//   cc_{req,rsp,fwd}_almost_full  count >= DEPTH-1, stage 3 stalls on these
//   ni_valid/ni_class/ni_msg   registered injection message
//   ni_ready                   network interface accepts the held message
//   overflow_err               sticky drop flags {fwd, rsp, req}

module cc_outgoing_message_arbiter #(
  parameter int MSG_W        = 512,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cc_req_valid,
  input  logic [MSG_W-1:0] cc_req_msg,
  input  logic             cc_rsp_valid,
  input  logic [MSG_W-1:0] cc_rsp_msg,
  input  logic             cc_fwd_valid,
  input  logic [MSG_W-1:0] cc_fwd_msg,
  output logic             cc_req_almost_full,
  output logic             cc_rsp_almost_full,
  output logic             cc_fwd_almost_full,
  output logic             ni_valid,
  output logic [1:0]       ni_class,
  output logic [MSG_W-1:0] ni_msg,
  input  logic             ni_ready,
  output logic [2:0]       overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C       = CW'(DEPTH - 1);
  localparam logic [SW-1:0] STARVE_C   = SW'(STARVE_LIMIT);

  localparam logic [1:0] CLS_REQ = 2'd0;
  localparam logic [1:0] CLS_RSP = 2'd1;
  localparam logic [1:0] CLS_FWD = 2'd2;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } state_t;

  state_t state, state_nx;

  logic [2:0]       enq;
  logic [2:0]       nonempty;
  logic [2:0]       almost_full;
  logic [2:0]       pop;
  logic [2:0]       drop;
  logic [MSG_W-1:0] enq_msg [3];
  logic [MSG_W-1:0] head    [3];

  logic             load;
  logic             any_pending;
  logic [1:0]       grant;
  logic [MSG_W-1:0] win_msg;
  logic [SW-1:0]    starve_cnt;
  logic [2:0]       overflow_q;

  assign enq        = {cc_fwd_valid, cc_rsp_valid, cc_req_valid};
  assign enq_msg[0] = cc_req_msg;
  assign enq_msg[1] = cc_rsp_msg;
  assign enq_msg[2] = cc_fwd_msg;

  // One circular FIFO per class. A full FIFO still accepts when it is popped
  // in the same cycle: the freed slot takes the new message.
  for (genvar c = 0; c < 3; c++) begin : g_fifo
    logic [MSG_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             accept;

    assign full           = (count == DEPTH_C);
    assign accept         = enq[c] && (!full || pop[c]);
    assign drop[c]        = enq[c] && full && !pop[c];
    assign nonempty[c]    = (count != '0);
    assign almost_full[c] = (count >= AF_C);
    assign head[c]        = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        if (pop[c]) rd_ptr <= rd_ptr + 1'b1;
        count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop[c]};
      end
    end

    // Storage needs no reset: it is only read when count says it is valid.
    always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= enq_msg[c];
    end
  end

  assign cc_req_almost_full = almost_full[0];
  assign cc_rsp_almost_full = almost_full[1];
  assign cc_fwd_almost_full = almost_full[2];

  // The output register reloads whenever it is empty or its message leaves.
  assign load        = (state == S_EMPTY) || ni_ready;
  assign any_pending = |nonempty;

  always_comb begin
    grant = CLS_REQ;
    if ((starve_cnt == STARVE_C) && nonempty[0]) grant = CLS_REQ;
    else if (nonempty[1])                        grant = CLS_RSP;
    else if (nonempty[2])                        grant = CLS_FWD;
    else                                         grant = CLS_REQ;
  end

  always_comb begin
    win_msg = head[0];
    case (grant)
      CLS_RSP: win_msg = head[1];
      CLS_FWD: win_msg = head[2];
      default: win_msg = head[0];
    endcase
  end

  assign pop = (load && any_pending) ? (3'b001 << grant) : 3'b000;

  always_comb begin
    state_nx = state;
    if (load) state_nx = any_pending ? S_FULL : S_EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_EMPTY;
    else        state <= state_nx;
  end

  assign ni_valid = (state == S_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ni_class <= CLS_REQ;
      ni_msg   <= '0;
    end else if (load && any_pending) begin
      ni_class <= grant;
      ni_msg   <= win_msg;
    end
  end

  // Counts loads lost by a waiting request; saturates at the force point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!nonempty[0]) begin
      starve_cnt <= '0;
    end else if (load && any_pending) begin
      if (grant == CLS_REQ)          starve_cnt <= '0;
      else if (starve_cnt != STARVE_C) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= '0;
    else        overflow_q <= overflow_q | drop;
  end

  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cc_outgoing_message_arbiter.sv
// tb/tb_cc_outgoing_message_arbiter.sv - directed self-checking bench for cc_outgoing_message_arbiter

module tb_cc_outgoing_message_arbiter;

  localparam int MSG_W = 512;

  logic             clk = 1'b0;
  logic             reset;
  logic             cc_req_valid, cc_rsp_valid, cc_fwd_valid;
  logic [MSG_W-1:0] cc_req_msg, cc_rsp_msg, cc_fwd_msg;
  logic             cc_req_almost_full, cc_rsp_almost_full, cc_fwd_almost_full;
  logic             ni_valid;
  logic [1:0]       ni_class;
  logic [MSG_W-1:0] ni_msg;
  logic             ni_ready;
  logic [2:0]       overflow_err;

  int n_total = 0;
  int n_bad   = 0;

  cc_outgoing_message_arbiter #(
    .MSG_W(MSG_W),
    .DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cc_req_valid      (cc_req_valid),
    .cc_req_msg        (cc_req_msg),
    .cc_rsp_valid      (cc_rsp_valid),
    .cc_rsp_msg        (cc_rsp_msg),
    .cc_fwd_valid      (cc_fwd_valid),
    .cc_fwd_msg        (cc_fwd_msg),
    .cc_req_almost_full(cc_req_almost_full),
    .cc_rsp_almost_full(cc_rsp_almost_full),
    .cc_fwd_almost_full(cc_fwd_almost_full),
    .ni_valid          (ni_valid),
    .ni_class          (ni_class),
    .ni_msg            (ni_msg),
    .ni_ready          (ni_ready),
    .overflow_err      (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MSG_W-1:0] got, input logic [MSG_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] cls, input logic [MSG_W-1:0] msg);
    chk({tag, "_valid"}, ni_valid, v);
    if (v) begin
      chk({tag, "_class"}, ni_class, cls);
      chk({tag, "_msg"}, ni_msg, msg);
    end
  endtask

  task automatic clear_inputs();
    cc_req_valid = 0; cc_rsp_valid = 0; cc_fwd_valid = 0;
    cc_req_msg = '0; cc_rsp_msg = '0; cc_fwd_msg = '0;
  endtask

  initial begin
    clear_inputs();
    ni_ready = 1'b0;
    reset    = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_valid", ni_valid, 1'b0);
    chk("rst_class", ni_class, 2'd0);
    chk("rst_msg", ni_msg, '0);
    chk("rst_ovf", overflow_err, 3'b000);
    chk("rst_af", {cc_fwd_almost_full, cc_rsp_almost_full, cc_req_almost_full}, 3'b000);
    reset = 1'b1;
    tick();

    // single response: visible one edge after the enqueue edge
    ni_ready = 1'b1;
    cc_rsp_valid = 1'b1; cc_rsp_msg = 'hA5;
    tick();
    clear_inputs();
    chk("single_lat0", ni_valid, 1'b0);
    tick();
    chk_out("single", 1'b1, 2'd1, 'hA5);
    tick();
    chk("single_gone", ni_valid, 1'b0);

    // priority rsp > fwd > req
    cc_req_valid = 1; cc_req_msg = 'h100;
    cc_rsp_valid = 1; cc_rsp_msg = 'h101;
    cc_fwd_valid = 1; cc_fwd_msg = 'h102;
    tick();
    clear_inputs();
    tick(); chk_out("prio_s0", 1'b1, 2'd1, 'h101);
    tick(); chk_out("prio_f0", 1'b1, 2'd2, 'h102);
    tick(); chk_out("prio_r0", 1'b1, 2'd0, 'h100);
    tick(); chk("prio_idle", ni_valid, 1'b0);

    // back-pressure with 4 requests
    ni_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cc_req_valid = 1; cc_req_msg = MSG_W'(32'h10 + i);
      tick();
      if (i == 2) chk("bp_af_cnt2", cc_req_almost_full, 1'b0);
      if (i == 3) chk("bp_af_cnt3", cc_req_almost_full, 1'b1);
    end
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      chk_out("bp_hold", 1'b1, 2'd0, 'h10);
      tick();
    end
    ni_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      tick();
      chk_out("bp_drain", 1'b1, 2'd0, MSG_W'(32'h10 + j));
    end
    tick();
    chk("bp_idle", ni_valid, 1'b0);
    chk("bp_af_clr", cc_req_almost_full, 1'b0);

    // starvation: one request against a continuous response stream
    for (int i = 0; i < 10; i++) begin
      cc_rsp_valid = 1; cc_rsp_msg = MSG_W'(32'h200 + i);
      cc_req_valid = (i == 0); cc_req_msg = 'h300;
      tick();
      if (i >= 1 && i <= 8) chk_out("starve_rsp", 1'b1, 2'd1, MSG_W'(32'h200 + i - 1));
      if (i == 9) begin
        chk_out("starve_req", 1'b1, 2'd0, 'h300);
        chk("starve_cnt0", dut.starve_cnt, '0);
      end
    end
    clear_inputs();
    tick(); chk_out("starve_s8", 1'b1, 2'd1, 'h208);
    tick(); chk_out("starve_s9", 1'b1, 2'd1, 'h209);
    tick(); chk("starve_idle", ni_valid, 1'b0);

    // overflow: 6 forwards with the port stalled
    ni_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cc_fwd_valid = 1; cc_fwd_msg = MSG_W'(32'h40 + i);
      tick();
      if (i == 4) begin
        chk("ovf_none_yet", overflow_err, 3'b000);
        chk("ovf_af", cc_fwd_almost_full, 1'b1);
      end
      if (i == 5) chk("ovf_set", overflow_err, 3'b100);
    end
    clear_inputs();
    chk_out("ovf_head", 1'b1, 2'd2, 'h40);
    ni_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      tick();
      chk_out("ovf_drain", 1'b1, 2'd2, MSG_W'(32'h40 + j));
    end
    tick();
    chk("ovf_idle", ni_valid, 1'b0);
    chk("ovf_sticky", overflow_err, 3'b100);

    // async reset mid-operation
    ni_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cc_req_valid = 1; cc_req_msg = MSG_W'(32'h50 + i);
      tick();
    end
    clear_inputs();
    chk_out("ar_pre", 1'b1, 2'd0, 'h50);
    chk("ar_pre_af", cc_req_almost_full, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", ni_valid, 1'b0);
    chk("ar_ovf", overflow_err, 3'b000);
    chk("ar_af", {cc_fwd_almost_full, cc_rsp_almost_full, cc_req_almost_full}, 3'b000);
    chk("ar_msg", ni_msg, '0);
    tick();
    reset = 1'b1;
    ni_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_no_stale", ni_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/cc_outgoing_message_arbiter.md
Name: cc_outgoing_message_arbiter

Overview:
- Buffers the three outgoing coherence message classes (request, response, forwarded request) produced by the cache controller's last stage.
- Sequences them onto a single network-interface injection port with a valid/ready handshake.
- Fixed priority keeps responses draining to avoid protocol deadlock; a starvation counter guarantees requests forward progress.
- Sits between cache controller stage 4 and the network interface; back-pressures stage 3 through per-class almost-full flags.

Parameters:
- MSG_W, 512, width of a packed outgoing message: header, data and destination fields, treated as opaque.
- DEPTH, 4, entries per class FIFO; power of 2, at least 2.
- STARVE_LIMIT, 8, number of consecutive lost arbitrations after which the request class is force-granted; at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cc_req_valid  in  1  enqueue request message
- cc_req_msg  in  MSG_W  request payload
- cc_rsp_valid  in  1  enqueue response message
- cc_rsp_msg  in  MSG_W  response payload
- cc_fwd_valid  in  1  enqueue forwarded request
- cc_fwd_msg  in  MSG_W  forward payload
- cc_req_almost_full  out  1  request FIFO count ≥ DEPTH-1
- cc_rsp_almost_full  out  1  response FIFO count ≥ DEPTH-1
- cc_fwd_almost_full  out  1  forward FIFO count ≥ DEPTH-1
- ni_valid  out  1  injection message valid
- ni_class  out  2  0 = request, 1 = response, 2 = forward; 3 is never driven
- ni_msg  out  MSG_W  injection payload
- ni_ready  in  1  network interface accepts the message
- overflow_err  out  3  sticky per-class drop flag; bit0 req, bit1 rsp, bit2 fwd

Behaviour:
- **Reset (reset = 0, asynchronous):**
  - All FIFOs are emptied and the starvation counter is set to 0.
  - ni_valid = 0, ni_class = 0, ni_msg = 0, overflow_err = 0.
  - All almost_full outputs = 0.
  - Reset asserted mid-transfer discards the held output and all buffered messages; nothing is replayed after reset.
- **FIFOs:**
  - One circular FIFO per class with DEPTH entries.
  - Pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
  - An enqueue is accepted if count < DEPTH, or if count == DEPTH and the same FIFO is dequeued in the same cycle. In the latter case count is unchanged and the message is written to the freed slot.
  - Any other enqueue on a full FIFO drops the message and sets the matching overflow_err bit. The bit stays set until reset.
  - almost_full is combinational from count. Stage 3 must stall on it, because stage 4 has no ready.
- **Output register (two states):**
  - EMPTY: ni_valid = 0.
  - FULL: ni_valid = 1; ni_class and ni_msg are held stable until ni_ready = 1.
  - Load condition: state EMPTY, or state FULL with ni_ready = 1. This gives back-to-back throughput of 1 message per cycle.
  - On load with at least one FIFO non-empty: pop the winning FIFO head into the register and go to (or stay in) FULL.
  - On load with all FIFOs empty: go to EMPTY.
- **Latency:** a message enqueued at edge N into an empty block appears on ni_valid after edge N+1. There is no combinational path from cc_*_valid to ni_*.
- **Arbitration at each load:**
  - Force: if starve_cnt == STARVE_LIMIT and the request FIFO is non-empty, grant request.
  - Otherwise fixed priority: response > forward > request.
- **starve_cnt:**
  - Cleared when the request FIFO is empty or request is granted.
  - Incremented, saturating at STARVE_LIMIT, on a load that grants another class while the request FIFO is non-empty.
  - Unchanged in cycles with no load.
- **Simultaneous enqueue and pop on the same FIFO** keeps count unchanged. Pop reads the old head; the new message is written at the tail.
- **Enqueue into an empty FIFO in the same cycle as a load:** the new message is not visible to arbitration that cycle; there is no FIFO bypass.

Test Plan:
- Single response: reset, one cc_rsp_valid with msg = 0xA5, ni_ready = 1 → ni_valid = 1 with ni_class = 1 and ni_msg = 0xA5 exactly one cycle after the enqueue edge, then ni_valid = 0 the next cycle.
- Priority: enqueue req R0, rsp S0 and fwd F0 in the same cycle, ni_ready = 1 → output order S0, F0, R0 on three consecutive cycles with ni_class 1, 2, 0.
- Back-pressure: ni_ready = 0, enqueue 4 requests (DEPTH = 4) → 1 message is held on ni_msg and 3 remain queued. cc_req_almost_full = 1 once count reaches 3. ni_msg stays stable for 10 cycles; all 4 messages drain in order when ni_ready = 1.
- Starvation: keep the response FIFO continuously non-empty with ni_ready = 1 and 1 request queued, STARVE_LIMIT = 8 → 8 responses are granted, then the request is granted on the 9th load and starve_cnt returns to 0.
- Overflow: ni_ready = 0, enqueue 6 forwards (DEPTH = 4) → the first 5 are accepted (1 in the output register plus 4 in the FIFO), the 6th is dropped, and overflow_err = 3'b100 stays set until reset.
- Async reset mid-operation: drop reset to 0 between clock edges while ni_valid = 1 → ni_valid, overflow_err and all almost_full outputs go to 0 immediately. After release, no stale message appears.
